// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of {pc, inst} entries between
// instruction memory and decode, with a single-cycle flush.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives instruction memory, queues fetched
// words for decode and handles redirects from execute.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nRst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_count
);

  logic [31:0]  pc;
  logic         full;
  logic         empty;
  logic         deq;
  logic         enq;
  fetch_entry_t din;
  fetch_entry_t head;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;

  // A pop frees a slot in the same cycle, so a full FIFO can still
  // accept the next word while decode drains it.
  assign deq = out_valid && out_ready;
  assign enq = (!full || deq) && !redirect_valid;

  assign din.pc   = pc;
  assign din.inst = imem_inst;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (enq) begin
        pc <= pc + PC_STEP;
      end
      if (deq) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit streaming, stall,
// redirect, mid-stream reset and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        nRst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int vectors = 0;
  int errs    = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .nRst           (nRst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: program words at 0..12, address-derived words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h00F0_0193;
      32'hC:   return 32'h0140_0213;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [31:0] fc);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".inst"}, out_inst, inst);
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".fcnt"}, fetch_count, fc);
  endtask

  initial begin
    nRst           = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);

    // Stream with decode always ready.
    nRst      = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_out("s1", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 32'd0);
    tick();
    chk_out("s2", 1'b1, 32'h4, 32'h00A0_0113, 32'h8, 32'd1);
    tick();
    chk_out("s3", 1'b1, 32'h8, 32'h00F0_0193, 32'hC, 32'd2);
    tick();
    chk_out("s4", 1'b1, 32'hC, 32'h0140_0213, 32'h10, 32'd3);

    // Mid-stream reset; a redirect during reset is ignored.
    nRst           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    chk_out("rst2", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);

    // Decode stalls for 5 cycles; FIFO fills to DEPTH=2.
    nRst           = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    tick();
    chk_out("h1", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 32'd0);
    tick();
    chk_out("h2", 1'b1, 32'h0, 32'h0050_0093, 32'h8, 32'd0);
    tick();
    chk_out("h3", 1'b1, 32'h0, 32'h0050_0093, 32'h8, 32'd0);
    tick();
    chk_out("h4", 1'b1, 32'h0, 32'h0050_0093, 32'h8, 32'd0);
    tick();
    chk_out("h5", 1'b1, 32'h0, 32'h0050_0093, 32'h8, 32'd0);

    // Release: entries come out in order, none lost or repeated.
    out_ready = 1'b1;
    tick();
    chk_out("r1", 1'b1, 32'h4, 32'h00A0_0113, 32'hC, 32'd1);
    tick();
    chk_out("r2", 1'b1, 32'h8, 32'h00F0_0193, 32'h10, 32'd2);

    // Redirect to 0x40 while full and dequeuing.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    chk("j1.valid", {31'd0, out_valid}, 32'd0);
    chk("j1.addr", imem_addr, 32'h40);
    chk("j1.fcnt", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    tick();
    chk_out("j2", 1'b1, 32'h40, 32'hDEAD_0040, 32'h44, 32'd3);

    // Misaligned target: low bits dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    chk("m1.valid", {31'd0, out_valid}, 32'd0);
    chk("m1.addr", imem_addr, 32'h40);
    chk("m1.fcnt", fetch_count, 32'd4);
    redirect_valid = 1'b0;
    tick();
    chk_out("m2", 1'b1, 32'h40, 32'hDEAD_0040, 32'h44, 32'd4);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    chk("w1.addr", imem_addr, 32'hFFFF_FFFC);
    chk("w1.fcnt", fetch_count, 32'd5);
    redirect_valid = 1'b0;
    tick();
    chk_out("w2", 1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0, 32'd5);
    tick();
    chk_out("w3", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
